// File: rtl/alu_operand_seq.sv
// alu_operand_seq: debounced switch-driven operand sequencer for the 4-bit ALU
// Captures X, Y and op code on "next" presses; chains the ALU result back into X.
module alu_operand_seq #(
    parameter int WIDTH     = 4,
    parameter int OPW       = 3,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [OPW-1:0]   op_sw,
    input  logic             btn_next,
    input  logic             btn_clear,
    input  logic [WIDTH-1:0] result_in,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [OPW-1:0]   select,
    output logic [1:0]       state_led,
    output logic             exec_valid,
    output logic             exec_pulse,
    output logic [7:0]       exec_count
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [1:0] LOAD_X  = 2'b00;
    localparam logic [1:0] LOAD_Y  = 2'b01;
    localparam logic [1:0] LOAD_OP = 2'b10;
    localparam logic [1:0] EXEC    = 2'b11;
    logic [1:0] raw;
    logic [1:0] strb;
    logic [1:0] state;
    logic       nxt;
    logic       clr;
    assign raw = {btn_clear, btn_next};
    genvar i;
    for (i = 0; i < 2; i++) begin : g_db
        logic          s1;
        logic          s2;
        logic          lvl;
        logic          stb;
        logic [CW-1:0] cnt;
        logic          flip;
        // the strobe is registered on the same edge the level rises, so it is seen one cycle later
        assign flip = (s2 != lvl) && (cnt == CW'(DB_CYCLES - 1));
        always_ff @(posedge clk) begin
            if (rst) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                lvl <= 1'b0;
                stb <= 1'b0;
                cnt <= '0;
            end else begin
                s1  <= raw[i];
                s2  <= s1;
                cnt <= (s2 == lvl || flip) ? '0 : cnt + CW'(1);
                lvl <= lvl ^ flip;
                stb <= flip && !lvl;
            end
        end
        assign strb[i] = stb;
    end
    assign nxt        = strb[0];
    assign clr        = strb[1];
    assign state_led  = state;
    assign exec_valid = (state == EXEC);
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_X;
            x          <= '0;
            y          <= '0;
            select     <= '0;
            exec_pulse <= 1'b0;
            exec_count <= '0;
        end else begin
            exec_pulse <= 1'b0;
            if (clr) begin
                state  <= LOAD_X;
                x      <= '0;
                y      <= '0;
                select <= '0;
            end else if (nxt) begin
                case (state)
                    LOAD_X: begin
                        x     <= sw;
                        state <= LOAD_Y;
                    end
                    LOAD_Y: begin
                        y     <= sw;
                        state <= LOAD_OP;
                    end
                    LOAD_OP: begin
                        select     <= op_sw;
                        state      <= EXEC;
                        exec_pulse <= 1'b1;
                        exec_count <= (exec_count == 8'hff) ? exec_count : exec_count + 8'd1;
                    end
                    default: begin
                        x     <= result_in;
                        state <= LOAD_Y;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_operand_seq.sv
// tb_alu_operand_seq: directed and randomized checks against a sliding-window behavioural model
module tb_alu_operand_seq;
    localparam int DB = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = '0;
    logic [2:0] op_sw = '0;
    logic       btn_next = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] result_in = '0;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] select;
    logic [1:0] state_led;
    logic       exec_valid;
    logic       exec_pulse;
    logic [7:0] exec_count;
    alu_operand_seq #(.WIDTH(4), .OPW(3), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw), .btn_next(btn_next),
        .btn_clear(btn_clear), .result_in(result_in), .x(x), .y(y), .select(select),
        .state_led(state_led), .exec_valid(exec_valid), .exec_pulse(exec_pulse),
        .exec_count(exec_count)
    );
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;
    bit en = 1'b0;
    // model: raw samples per edge, h[0] newest; a level flips once DB synced samples all differ from it
    int hn [0:DB];
    int hc [0:DB];
    bit ln, lc, pn, pc, tn, tc;
    int m_state, m_x, m_y, m_sel, m_cnt, m_pulse;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= DB; k++) begin
                hn[k] = 0;
                hc[k] = 0;
            end
            ln = 0; lc = 0; pn = 0; pc = 0;
            m_state = 0; m_x = 0; m_y = 0; m_sel = 0; m_cnt = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (pc) begin
                m_state = 0; m_x = 0; m_y = 0; m_sel = 0;
            end else if (pn) begin
                if (m_state == 0) begin m_x = sw; m_state = 1; end
                else if (m_state == 1) begin m_y = sw; m_state = 2; end
                else if (m_state == 2) begin
                    m_sel = op_sw; m_state = 3; m_pulse = 1;
                    if (m_cnt < 255) m_cnt++;
                end else begin m_x = result_in; m_state = 1; end
            end
            tn = 1; tc = 1;
            for (int k = 1; k <= DB; k++) begin
                if (hn[k] == int'(ln)) tn = 0;
                if (hc[k] == int'(lc)) tc = 0;
            end
            pn = tn && !ln;
            pc = tc && !lc;
            ln = ln ^ tn;
            lc = lc ^ tc;
            for (int k = DB; k > 0; k--) begin
                hn[k] = hn[k-1];
                hc[k] = hc[k-1];
            end
            hn[0] = btn_next;
            hc[0] = btn_clear;
        end
    end
    always @(negedge clk) begin
        if (en) begin
            chk("x", x, m_x);
            chk("y", y, m_y);
            chk("select", select, m_sel);
            chk("state_led", state_led, m_state);
            chk("exec_valid", exec_valid, m_state == 3);
            chk("exec_pulse", exec_pulse, m_pulse);
            chk("exec_count", exec_count, m_cnt);
            if (exec_pulse) pulses++;
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press(input bit nx, input bit c);
        btn_next = nx;
        btn_clear = c;
        tick(7);
        btn_next = 0;
        btn_clear = 0;
        tick(8);
    endtask
    int p0, lat;
    logic [1:0] prev;
    initial begin
        tick(1);
        en = 1;
        tick(1);
        chk("rst_state", state_led, 0);
        chk("rst_x", x, 0);
        chk("rst_count", exec_count, 0);
        chk("rst_valid", exec_valid, 0);
        rst = 0;
        tick(2);
        p0 = pulses;
        sw = 3; press(1, 0);
        sw = 5; press(1, 0);
        op_sw = 0; press(1, 0);
        chk("load_x", x, 3);
        chk("load_y", y, 5);
        chk("load_state", state_led, 3);
        chk("load_count", exec_count, 1);
        chk("load_pulses", pulses - p0, 1);
        chk("model_x", m_x, 3);
        chk("model_cnt", m_cnt, 1);
        result_in = 8;
        for (int r = 0; r < 4; r++) begin
            btn_next = 1; tick(3);
            btn_next = 0; tick(1);
        end
        chk("bounce_state", state_led, 3);
        prev = state_led;
        btn_next = 1;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (state_led == prev && lat < 20);
        chk("latency", lat, 7);
        @(negedge clk);
        tick(3);
        btn_next = 0;
        tick(8);
        chk("chain_x", x, 8);
        chk("chain_state", state_led, 1);
        chk("chain_y", y, 5);
        chk("chain_sel", select, 0);
        press(1, 0);
        press(1, 0);
        chk("chain_exec", state_led, 3);
        chk("chain_count", exec_count, 2);
        press(1, 0);
        press(1, 0);
        chk("pre_clr_state", state_led, 2);
        press(1, 1);
        chk("clr_state", state_led, 0);
        chk("clr_x", x, 0);
        chk("clr_y", y, 0);
        chk("clr_sel", select, 0);
        chk("clr_count", exec_count, 2);
        sw = 9; op_sw = 5; result_in = 6;
        repeat (3) press(1, 0);
        for (int r = 0; r < 258; r++) repeat (3) press(1, 0);
        chk("sat_count", exec_count, 255);
        chk("model_sat", m_cnt, 255);
        chk("sat_sel", select, 5);
        btn_next = 1;
        tick(4);
        rst = 1;
        btn_next = 0;
        tick(1);
        rst = 0;
        tick(15);
        chk("rst_db_state", state_led, 0);
        chk("rst_db_count", exec_count, 0);
        for (int r = 0; r < 400; r++) begin
            sw = 4'($urandom);
            op_sw = 3'($urandom);
            result_in = 4'($urandom);
            btn_next = 1'($urandom_range(0, 1));
            btn_clear = ($urandom_range(0, 7) == 0);
            tick($urandom_range(1, 10));
        end
        btn_next = 0;
        btn_clear = 0;
        tick(10);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
